bcd_serial_adder: RTL
=====================

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning the number of BCD digits per operand; legal range is 1 to 16.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, meaning operands are offered.
REQ-005 SHALL have port in_ready, output, 1, meaning the block accepts operands.
REQ-006 SHALL have port a, input, 4*DIGITS, the first BCD operand; digit 0 is in bits [3:0].
REQ-007 SHALL have port b, input, 4*DIGITS, the second BCD operand, with the same digit order as a.
REQ-008 SHALL have port cin, input, 1, the decimal carry-in, or the borrow-in in subtract mode.
REQ-009 SHALL have port sub, input, 1, the operation select: 1 = subtract, 0 = add.
REQ-010 SHALL have port out_valid, output, 1, meaning the result is presented.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-012 SHALL have port sum, output, 4*DIGITS, the BCD result.
REQ-013 SHALL have port cout, output, 1, the decimal carry-out, or the not-borrow flag in subtract mode.
REQ-014 SHALL have port err, output, 1, meaning at least one digit of the latched a or b was greater than 9.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-017 SHALL accept operands when in_valid=1 and in_ready=1 on the same edge:
- latch a, b, cin and sub;
- clear the digit index to 0;
- move to RUN.
REQ-018 SHALL process one digit per RUN cycle, starting at digit 0, as follows:
- t = a_d + b'_d + c, with 5-bit width;
- if t > 9, write sum digit = (t+6) mod 16 and set c = 1;
- otherwise write sum digit = t and set c = 0.
REQ-019 SHALL set the initial c to cin in add mode; b'_d SHALL equal b_d.
REQ-020 SHALL move from RUN to DONE after digit DIGITS-1 is processed, and register the final c into cout.
REQ-021 SHALL assert out_valid exactly DIGITS+1 cycles after the accepting edge.
REQ-022 SHALL hold sum, cout and err stable in DONE until out_valid=1 and out_ready=1, then return to IDLE.
- in_ready=1 on the following cycle.
REQ-023 SHALL ignore in_valid outside IDLE.
REQ-024 SHALL give out_ready no effect outside DONE.
REQ-025 SHALL compute err at acceptance as the OR of (digit > 9) over all digits of a and b.
- When err=1, sum SHALL still follow REQ-018 on the raw digits.
REQ-026 SHALL give 9..9 + 9..9 + cin=1 the result sum=9..9, cout=1; no digit SHALL exceed 9 for legal inputs.
REQ-027 SHALL make the result consistent with the operands latched at acceptance; later changes on a, b, cin or sub SHALL have no effect.

Reset
REQ-028 SHALL, with rst=1 at an edge:
- force the state to IDLE and the digit index to 0;
- set sum=0, cout=0, err=0, out_valid=0.
REQ-029 SHALL present in_ready=1 on the first cycle after rst deasserts.
REQ-030 SHALL let rst abort a RUN or DONE operation with no result delivered; rst SHALL take priority over any handshake on the same edge.

Configuration
REQ-031 SHALL use macro BCD_SERIAL_ADDER_SUB_EN to select subtract support.
REQ-032 SHALL, with BCD_SERIAL_ADDER_SUB_EN defined and sub=1:
- use b'_d = 9 - b_d (nines complement);
- set the initial c = ~cin;
- cout=1 means no borrow (A >= B + cin);
- cout=0 means sum is the ten's complement of the magnitude.
REQ-033 SHALL, without BCD_SERIAL_ADDER_SUB_EN, ignore sub and always add, with no complement logic synthesised.

Verification (DIGITS=4)
REQ-034 SHALL cover: a=0x1234, b=0x5678, cin=0 -> sum=0x6912, cout=0, err=0, out_valid 5 cycles after acceptance.
REQ-035 SHALL cover: a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1; and a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1.
REQ-036 SHALL cover: a=0x12A4, b=0x0000 -> err=1; a following legal pair -> err=0.
REQ-037 SHALL cover: out_ready held low 3 cycles in DONE -> sum/cout stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-038 SHALL cover: rst pulsed on the 2nd RUN cycle -> next cycle IDLE, out_valid=0, sum=0, in_ready=1.
REQ-039 SHALL cover (BCD_SERIAL_ADDER_SUB_EN, sub=1, cin=0): 0x0100-0x0001 -> sum=0x0099, cout=1; 0x0001-0x0002 -> sum=0x9999, cout=0.

Source files
------------

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder: one decimal digit per clock, with a valid/ready handshake on both sides.
// Define BCD_SERIAL_ADDER_SUB_EN to add nines-complement subtraction; without it, sub is ignored.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS + 1);

  // state   | meaning
  // S_IDLE  | waiting for operands, in_ready=1
  // S_RUN   | one digit per cycle, then one cycle to register cout
  // S_DONE  | result held until out_ready
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic [IW-1:0]   r_idx;
  logic            r_c;
  logic            r_cout;
  logic            r_err;
  logic            r_in_ready;
  logic            r_out_valid;

  logic [3:0]      w_b_d;
  logic [4:0]      w_t;
  logic            w_gt9;
  logic [3:0]      w_digit;
  logic [W-1:0]    w_ins;
  logic            w_err_in;
  logic            w_c_init;

`ifdef BCD_SERIAL_ADDER_SUB_EN
  logic            r_sub;
  assign w_b_d    = r_sub ? (4'd9 - r_b[3:0]) : r_b[3:0];
  assign w_c_init = sub ? ~cin : cin;
`else
  logic            w_unused_sub;
  assign w_unused_sub = sub;
  assign w_b_d    = r_b[3:0];
  assign w_c_init = cin;
`endif

  // Operands shift right one digit per cycle; the result digit enters at the top.
  assign w_t     = {1'b0, r_a[3:0]} + {1'b0, w_b_d} + {4'b0000, r_c};
  assign w_gt9   = (w_t > 5'd9);
  assign w_digit = w_gt9 ? (w_t[3:0] + 4'd6) : w_t[3:0];
  assign w_ins   = W'(w_digit) << (W - 4);

  always_comb begin
    w_err_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) w_err_in = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_idx       <= '0;
      r_c         <= 1'b0;
      r_cout      <= 1'b0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef BCD_SERIAL_ADDER_SUB_EN
      r_sub       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_c        <= w_c_init;
            r_err      <= w_err_in;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
`ifdef BCD_SERIAL_ADDER_SUB_EN
            r_sub      <= sub;
`endif
          end
        end
        S_RUN: begin
          if (r_idx == IW'(DIGITS)) begin
            r_cout      <= r_c;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_sum <= (r_sum >> 4) | w_ins;
            r_a   <= r_a >> 4;
            r_b   <= r_b >> 4;
            r_c   <= w_gt9;
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign err       = r_err;

endmodule
